// File: rtl/switch_debounce_pkg.sv
// ============================================================================
// Module   : switch_debounce_pkg
// Brief    : Shared FSM state encoding and press-counter width for the
//            switch debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_debounce_pkg;

    localparam int PRESS_CNT_W = 16;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// Module   : sync_chain
// Brief    : Multi-flop synchronizer for one asynchronous level, with a
//            synchronous flush used while the debouncer is disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else if (clr) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// Module   : switch_debounce
// Brief    : Synchronizes and debounces a mechanical switch, producing a clean
//            level plus rise/fall pulses. Define SWITCH_DEBOUNCE_PRESS_CNT_EN
//            to add a 16-bit press counter with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   pclk,
    input  logic                   nreset,
    input  logic                   switch_raw,
    input  logic                   enable,
`ifdef SWITCH_DEBOUNCE_PRESS_CNT_EN
    input  logic                   cnt_clr,
    output logic [PRESS_CNT_W-1:0] press_count,
`endif
    output logic                   switch_clean,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic                   busy
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync_q;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    // Flushing the chain while disabled makes re-enable restart the full latency.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (pclk),
        .rst_n (nreset),
        .clr   (!enable),
        .d     (switch_raw),
        .q     (w_sync_q)
    );

    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_LOW;
            r_cnt        <= '0;
            switch_clean <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (!enable) begin
                r_state      <= S_LOW;
                r_cnt        <= '0;
                switch_clean <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (r_state)
                    S_LOW: begin
                        if (w_sync_q) begin
                            r_state <= S_RISE_WAIT;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    S_RISE_WAIT: begin
                        if (!w_sync_q) begin
                            r_state <= S_LOW;
                            busy    <= 1'b0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state      <= S_HIGH;
                            switch_clean <= 1'b1;
                            rise_pulse   <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (!w_sync_q) begin
                            r_state <= S_FALL_WAIT;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    S_FALL_WAIT: begin
                        if (w_sync_q) begin
                            r_state <= S_HIGH;
                            busy    <= 1'b0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state      <= S_LOW;
                            switch_clean <= 1'b0;
                            fall_pulse   <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state      <= S_LOW;
                        r_cnt        <= '0;
                        switch_clean <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_PRESS_CNT_EN
    // Clear has priority over a coincident press.
    always_ff @(posedge pclk or negedge nreset) begin
        if (!nreset) begin
            press_count <= '0;
        end else if (cnt_clr) begin
            press_count <= '0;
        end else if (rise_pulse) begin
            press_count <= press_count + PRESS_CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on switch_raw (legal >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable pclk cycles required to accept a level change (legal >= 1).
REQ-003 SHALL have port pclk  input  1  single clock for all logic.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port switch_raw  input  1  asynchronous, bouncing mechanical switch level.
REQ-006 SHALL have port enable  input  1  debouncer enable; low forces idle.
REQ-007 SHALL have port switch_clean  output  1  debounced level; drives the timer switch/capture input.
REQ-008 SHALL have port rise_pulse  output  1  one-cycle pulse on accepted 0->1 change.
REQ-009 SHALL have port fall_pulse  output  1  one-cycle pulse on accepted 1->0 change.
REQ-010 SHALL have port busy  output  1  high while in S_RISE_WAIT or S_FALL_WAIT.

Function
REQ-011 SHALL pass switch_raw through a SYNC_STAGES-flop chain; only the last stage (sync_q) feeds the FSM.
REQ-012 SHALL implement FSM states S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT.
REQ-013 S_LOW: sync_q=1 -> S_RISE_WAIT, cnt<=0; else stay.
REQ-014 S_RISE_WAIT: sync_q=0 -> S_LOW (bounce rejected, no pulse); cnt==DEBOUNCE_CYCLES-1 -> S_HIGH; else cnt<=cnt+1.
REQ-015 S_HIGH: sync_q=0 -> S_FALL_WAIT, cnt<=0; else stay.
REQ-016 S_FALL_WAIT: sync_q=1 -> S_HIGH (no pulse); cnt==DEBOUNCE_CYCLES-1 -> S_LOW; else cnt<=cnt+1.
REQ-017 switch_clean SHALL be registered, high exactly in S_HIGH and S_FALL_WAIT.
REQ-018 Latency: if switch_raw is first sampled 1 at edge E0 and stays 1, switch_clean SHALL rise after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES; falling is symmetric.
REQ-019 rise_pulse SHALL be high for exactly the one cycle following the S_RISE_WAIT->S_HIGH transition, coincident with switch_clean first reading 1; fall_pulse likewise for S_FALL_WAIT->S_LOW.
REQ-020 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-021 enable=0 SHALL force S_LOW, cnt=0, switch_clean=0, no pulses, same cycle-edge, regardless of state; deassert from S_HIGH SHALL NOT produce fall_pulse.
REQ-022 After enable rises with switch_raw held high, a full debounce (REQ-018 timing from the rising enable edge) SHALL occur before switch_clean=1.

Reset
REQ-023 nreset low SHALL asynchronously clear sync chain, cnt, state (S_LOW), switch_clean, rise_pulse, fall_pulse, busy to 0.
REQ-024 Reset mid-debounce SHALL discard progress; no pulse on or after reset release until a full new debounce completes.

Configuration
REQ-025 Macro SWITCH_DEBOUNCE_PRESS_CNT_EN defined: SHALL add ports cnt_clr input 1 and press_count output 16; press_count increments on each rise_pulse, wraps 0xFFFF->0x0000, cnt_clr synchronous clear, clear wins over a coincident increment (result 0), reset value 0.
REQ-026 Macro undefined: SHALL omit those ports and the counter entirely; all other behaviour identical.

Structure
REQ-027 Package switch_debounce_pkg SHALL hold the FSM state typedef (2-bit encoding) and PRESS_CNT_W=16.
REQ-028 Synchronizer SHALL be sub-module sync_chain (parameter STAGES, async active-low reset, reset value 0); all else in switch_debounce.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=8 unless stated)
REQ-029 Clean step: switch_raw 0->1 held -> switch_clean=1 and one-cycle rise_pulse exactly 10 edges after first sampled 1; busy high for 8 cycles prior.
REQ-030 Bounce: switch_raw high 5 cycles, low 1, high held -> no pulse at glitch; switch_clean rises 10 edges after final rise; exactly one rise_pulse.
REQ-031 Release with bounce: from S_HIGH, raw low 3, high 2, low held -> one fall_pulse, switch_clean falls 10 edges after final low.
REQ-032 Async reset asserted at cnt=4 in S_RISE_WAIT -> all outputs 0 immediately; after release with raw high, rise_pulse only after full 10 edges.
REQ-033 enable dropped in S_HIGH -> switch_clean=0 next edge, fall_pulse never asserted.
REQ-034 With SWITCH_DEBOUNCE_PRESS_CNT_EN, DEBOUNCE_CYCLES=1: preload via 65535 presses -> press_count=0xFFFF, next press -> 0x0000; cnt_clr coincident with rise_pulse -> 0.
